// File: rtl/ctrl_decode_pipe.sv
// ctrl_decode_pipe: ID-stage main decoder feeding the ID/EX control register, with IRQ arbiter.
// Optional syscall decode (opcode 00 / funct 0c) is enabled by defining CTRL_SYSCALL_EN.
module ctrl_decode_pipe #(
   parameter int NUM_IRQ  = 4,
   parameter int IRQ_ID_W = 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                id_valid,
   input  logic [5:0]          opcode,
   input  logic [5:0]          funct,
   input  logic                kernel,
   input  logic                stall,
   input  logic                flush,
   input  logic [NUM_IRQ-1:0]  irq_req,
   input  logic [NUM_IRQ-1:0]  irq_mask,
   output logic [2:0]          pcsrc,
   output logic                sign,
   output logic                regwrite,
   output logic                memread,
   output logic                memwrite,
   output logic                alusrc1,
   output logic                alusrc2,
   output logic                extop,
   output logic                luop,
   output logic [1:0]          regdst,
   output logic [1:0]          memtoreg,
   output logic [5:0]          alufun,
   output logic [1:0]          exc_cause,
   output logic [IRQ_ID_W-1:0] irq_id,
   output logic [NUM_IRQ-1:0]  irq_pending
);

   typedef struct packed {
      logic [2:0]          pcsrc;
      logic                sign;
      logic                regwrite;
      logic                memread;
      logic                memwrite;
      logic                alusrc1;
      logic                alusrc2;
      logic                extop;
      logic                luop;
      logic [1:0]          regdst;
      logic [1:0]          memtoreg;
      logic [5:0]          alufun;
      logic [1:0]          excCause;
      logic [IRQ_ID_W-1:0] irqId;
   } CtrlBundle;

   localparam CtrlBundle Bubble = '0;

   CtrlBundle           idexReg;
   CtrlBundle           decoded;
   CtrlBundle           nextCtrl;
   logic [NUM_IRQ-1:0]  irqPrev;
   logic [NUM_IRQ-1:0]  irqPendingReg;
   logic [NUM_IRQ-1:0]  irqEligible;
   logic [NUM_IRQ-1:0]  irqOneHot;
   logic [NUM_IRQ-1:0]  irqClear;
   logic [NUM_IRQ-1:0]  irqEdge;
   logic                irqAccept;
   logic [IRQ_ID_W-1:0] irqWinner;
   logic                undefinedOp;
   logic                isSyscall;

   always_comb begin
      decoded         = Bubble;
      decoded.sign    = 1'b1;
      decoded.extop   = 1'b1;
      decoded.alusrc2 = 1'b1;
      undefinedOp     = 1'b0;
      isSyscall       = 1'b0;
      case (opcode)
         6'h00: begin
            decoded.alusrc2  = 1'b0;
            decoded.regdst   = 2'b01;
            decoded.regwrite = 1'b1;
            case (funct)
               6'h00: begin decoded.alusrc1 = 1'b1; decoded.alufun = 6'b100000; end
               6'h02: begin decoded.alusrc1 = 1'b1; decoded.alufun = 6'b100001; end
               6'h03: begin decoded.alusrc1 = 1'b1; decoded.alufun = 6'b100011; end
               6'h08: begin decoded.regwrite = 1'b0; decoded.pcsrc = 3'b011; end
               6'h09: begin decoded.pcsrc = 3'b011; decoded.memtoreg = 2'b10; end
`ifdef CTRL_SYSCALL_EN
               6'h0c: isSyscall = 1'b1;
`endif
               6'h20, 6'h21: decoded.alufun = 6'b000000;
               6'h22, 6'h23: decoded.alufun = 6'b000001;
               6'h24: decoded.alufun = 6'b011000;
               6'h25: decoded.alufun = 6'b011110;
               6'h26: decoded.alufun = 6'b010110;
               6'h27: decoded.alufun = 6'b010001;
               6'h2a: decoded.alufun = 6'b110101;
               6'h2b: begin decoded.alufun = 6'b110101; decoded.sign = 1'b0; end
               default: ;
            endcase
         end
         6'h01: begin decoded.pcsrc = 3'b001; decoded.alufun = 6'b111011; end
         6'h02: decoded.pcsrc = 3'b010;
         6'h03: begin
            decoded.pcsrc    = 3'b010;
            decoded.regwrite = 1'b1;
            decoded.regdst   = 2'b10;
            decoded.memtoreg = 2'b10;
         end
         6'h04: begin decoded.pcsrc = 3'b001; decoded.alusrc2 = 1'b0; decoded.alufun = 6'b110011; end
         6'h05: begin decoded.pcsrc = 3'b001; decoded.alufun = 6'b110001; end
         6'h06: begin decoded.pcsrc = 3'b001; decoded.alufun = 6'b111101; end
         6'h07: begin decoded.pcsrc = 3'b001; decoded.alufun = 6'b111111; end
         6'h08, 6'h09: decoded.regwrite = 1'b1;
         6'h0a: begin decoded.regwrite = 1'b1; decoded.alufun = 6'b110101; end
         6'h0b: begin decoded.regwrite = 1'b1; decoded.alufun = 6'b110101; decoded.sign = 1'b0; end
         6'h0c: begin decoded.regwrite = 1'b1; decoded.alufun = 6'b011000; decoded.extop = 1'b0; end
         6'h0f: begin decoded.regwrite = 1'b1; decoded.luop = 1'b1; end
         6'h23: begin decoded.regwrite = 1'b1; decoded.memread = 1'b1; decoded.memtoreg = 2'b01; end
         6'h2b: decoded.memwrite = 1'b1;
         default: undefinedOp = 1'b1;
      endcase
   end

   // Lowest-index eligible line wins; isolating the lowest set bit gives the clear mask directly.
   always_comb begin
      irqEligible = irqPendingReg & irq_mask;
      irqOneHot   = irqEligible & (~irqEligible + NUM_IRQ'(1));
      irqAccept   = id_valid & ~stall & ~flush & ~kernel & (|irqEligible);
      irqClear    = irqAccept ? irqOneHot : '0;
      irqEdge     = irq_req & ~irqPrev;
      irqWinner   = '0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (irqEligible[i]) irqWinner = IRQ_ID_W'(i);
      end
   end

   always_comb begin
      nextCtrl = Bubble;
      if (!id_valid) begin
         nextCtrl = Bubble;
      end else if (irqAccept) begin
         nextCtrl.pcsrc    = 3'b100;
         nextCtrl.regwrite = 1'b1;
         nextCtrl.regdst   = 2'b11;
         nextCtrl.memtoreg = 2'b11;
         nextCtrl.excCause = 2'b01;
         nextCtrl.irqId    = irqWinner;
      end else if (undefinedOp || isSyscall) begin
         nextCtrl.pcsrc    = 3'b101;
         nextCtrl.regwrite = 1'b1;
         nextCtrl.regdst   = 2'b11;
         nextCtrl.memtoreg = 2'b10;
         nextCtrl.excCause = undefinedOp ? 2'b10 : 2'b11;
      end else begin
         nextCtrl = decoded;
      end
   end

   // Pending bits keep latching edges while stalled; set is applied after clear so it wins.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         idexReg       <= Bubble;
         irqPendingReg <= '0;
         irqPrev       <= '0;
      end else begin
         irqPrev       <= irq_req;
         irqPendingReg <= (irqPendingReg & ~irqClear) | irqEdge;
         if (flush) begin
            idexReg <= Bubble;
         end else if (!stall) begin
            idexReg <= nextCtrl;
         end
      end
   end

   assign pcsrc       = idexReg.pcsrc;
   assign sign        = idexReg.sign;
   assign regwrite    = idexReg.regwrite;
   assign memread     = idexReg.memread;
   assign memwrite    = idexReg.memwrite;
   assign alusrc1     = idexReg.alusrc1;
   assign alusrc2     = idexReg.alusrc2;
   assign extop       = idexReg.extop;
   assign luop        = idexReg.luop;
   assign regdst      = idexReg.regdst;
   assign memtoreg    = idexReg.memtoreg;
   assign alufun      = idexReg.alufun;
   assign exc_cause   = idexReg.excCause;
   assign irq_id      = idexReg.irqId;
   assign irq_pending = irqPendingReg;

endmodule

// File: tb/tb_ctrl_decode_pipe.sv
// Scoreboard bench for ctrl_decode_pipe: directed scenarios plus random stimulus against a reference model.
// Honours CTRL_SYSCALL_EN the same way as the design.
module tb_ctrl_decode_pipe;

   typedef struct packed {
      logic [2:0] pcsrc;
      logic       sign;
      logic       regwrite;
      logic       memread;
      logic       memwrite;
      logic       alusrc1;
      logic       alusrc2;
      logic       extop;
      logic       luop;
      logic [1:0] regdst;
      logic [1:0] memtoreg;
      logic [5:0] alufun;
      logic [1:0] exc;
      logic [1:0] irqId;
   } CtrlView;

   typedef struct {
      CtrlView    ctrl;
      bit         full;
      logic [3:0] pending;
   } Expect;

   logic       clk = 1'b0;
   logic       resetN = 1'b0;
   logic       idValid = 1'b0;
   logic [5:0] opcode = '0;
   logic [5:0] funct = '0;
   logic       kernel = 1'b0;
   logic       stall = 1'b0;
   logic       flush = 1'b0;
   logic [3:0] irqReq = '0;
   logic [3:0] irqMask = '0;
   logic [2:0] pcsrc;
   logic       sign, regwrite, memread, memwrite, alusrc1, alusrc2, extop, luop;
   logic [1:0] regdst, memtoreg, excCause, irqId;
   logic [5:0] alufun;
   logic [3:0] irqPending;

   Expect      sb[$];
   int         checks = 0;
   int         errors = 0;
   logic [3:0] mPending = '0;
   logic [3:0] mPrev = '0;
   CtrlView    mHeld = '0;
   bit         mHeldFull = 1'b1;

   ctrl_decode_pipe dut (
      .clk(clk), .reset(resetN), .id_valid(idValid), .opcode(opcode), .funct(funct),
      .kernel(kernel), .stall(stall), .flush(flush), .irq_req(irqReq), .irq_mask(irqMask),
      .pcsrc(pcsrc), .sign(sign), .regwrite(regwrite), .memread(memread), .memwrite(memwrite),
      .alusrc1(alusrc1), .alusrc2(alusrc2), .extop(extop), .luop(luop), .regdst(regdst),
      .memtoreg(memtoreg), .alufun(alufun), .exc_cause(excCause), .irq_id(irqId),
      .irq_pending(irqPending)
   );

   always #5 clk = ~clk;

   // Instruction semantics written as per-field rules over the mnemonic set.
   function automatic void refCtrl(input logic [5:0] op, input logic [5:0] fn,
                                   output CtrlView c, output bit full);
      bit isR, rAdd, rSub, rAnd, rOr, rXor, rNor, rSll, rSrl, rSra, rSlt, rSltu, rJr, rJalr, rSys;
      bit iBltz, iJ, iJal, iBeq, iBne, iBlez, iBgtz, iAddi, iAddiu, iSlti, iSltiu, iAndi, iLui, iLw, iSw;
      bit known, branch;
      isR   = (op == 6'h00);
      rAdd  = isR && (fn == 6'h20 || fn == 6'h21);
      rSub  = isR && (fn == 6'h22 || fn == 6'h23);
      rAnd  = isR && fn == 6'h24;
      rOr   = isR && fn == 6'h25;
      rXor  = isR && fn == 6'h26;
      rNor  = isR && fn == 6'h27;
      rSll  = isR && fn == 6'h00;
      rSrl  = isR && fn == 6'h02;
      rSra  = isR && fn == 6'h03;
      rSlt  = isR && fn == 6'h2a;
      rSltu = isR && fn == 6'h2b;
      rJr   = isR && fn == 6'h08;
      rJalr = isR && fn == 6'h09;
`ifdef CTRL_SYSCALL_EN
      rSys  = isR && fn == 6'h0c;
`else
      rSys  = 1'b0;
`endif
      iBltz = op == 6'h01; iJ = op == 6'h02; iJal = op == 6'h03; iBeq = op == 6'h04;
      iBne = op == 6'h05; iBlez = op == 6'h06; iBgtz = op == 6'h07; iAddi = op == 6'h08;
      iAddiu = op == 6'h09; iSlti = op == 6'h0a; iSltiu = op == 6'h0b; iAndi = op == 6'h0c;
      iLui = op == 6'h0f; iLw = op == 6'h23; iSw = op == 6'h2b;
      known = isR | iBltz | iJ | iJal | iBeq | iBne | iBlez | iBgtz | iAddi | iAddiu |
              iSlti | iSltiu | iAndi | iLui | iLw | iSw;
      branch = iBltz | iBeq | iBne | iBlez | iBgtz;
      c = '0;
      full = 1'b1;
      if (!known || rSys) begin
         full       = 1'b0;
         c.pcsrc    = 3'd5;
         c.regwrite = 1'b1;
         c.regdst   = 2'd3;
         c.memtoreg = 2'd2;
         c.exc      = known ? 2'd3 : 2'd2;
         return;
      end
      c.pcsrc    = branch ? 3'd1 : (iJ | iJal) ? 3'd2 : (rJr | rJalr) ? 3'd3 : 3'd0;
      c.regwrite = !(branch | iJ | rJr | iSw);
      c.memread  = iLw;
      c.memwrite = iSw;
      c.sign     = !(rSltu | iSltiu);
      c.extop    = !iAndi;
      c.luop     = iLui;
      c.alusrc1  = rSll | rSrl | rSra;
      c.alusrc2  = !(isR | iBeq);
      c.regdst   = iJal ? 2'd2 : isR ? 2'd1 : 2'd0;
      c.memtoreg = iLw ? 2'd1 : (iJal | rJalr) ? 2'd2 : 2'd0;
      if (rSub)                              c.alufun = 6'b000001;
      else if (rAnd | iAndi)                 c.alufun = 6'b011000;
      else if (rOr)                          c.alufun = 6'b011110;
      else if (rXor)                         c.alufun = 6'b010110;
      else if (rNor)                         c.alufun = 6'b010001;
      else if (rSll)                         c.alufun = 6'b100000;
      else if (rSrl)                         c.alufun = 6'b100001;
      else if (rSra)                         c.alufun = 6'b100011;
      else if (rSlt | rSltu | iSlti | iSltiu) c.alufun = 6'b110101;
      else if (iBeq)                         c.alufun = 6'b110011;
      else if (iBne)                         c.alufun = 6'b110001;
      else if (iBlez)                        c.alufun = 6'b111101;
      else if (iBgtz)                        c.alufun = 6'b111111;
      else if (iBltz)                        c.alufun = 6'b111011;
      else                                   c.alufun = 6'b000000;
      if (rAdd) c.alufun = 6'b000000;
   endfunction

   // Exception bundles only define the fields that steer the trap; irq_id matters only for IRQs.
   function automatic CtrlView visible(input CtrlView c, input bit full, input logic [1:0] exc);
      CtrlView v;
      v = c;
      if (!full) begin
         v.sign = 1'b0; v.alusrc1 = 1'b0; v.alusrc2 = 1'b0;
         v.extop = 1'b0; v.luop = 1'b0; v.alufun = '0;
      end
      if (exc != 2'b01) v.irqId = '0;
      return v;
   endfunction

   task automatic applyStimulus(input bit v, input logic [5:0] op, input logic [5:0] fn,
                                input bit kern, input bit st, input bit fl,
                                input logic [3:0] req, input logic [3:0] msk);
      Expect      e;
      CtrlView    c;
      bit         full;
      bit         acc;
      int         win;
      logic [3:0] elig;
      logic [3:0] newPending;
      @(negedge clk);
      resetN = 1'b1; idValid = v; opcode = op; funct = fn; kernel = kern;
      stall = st; flush = fl; irqReq = req; irqMask = msk;
      elig = mPending & msk;
      acc  = v && !st && !fl && !kern && (elig != 4'b0);
      win  = 0;
      for (int i = 3; i >= 0; i--) if (elig[i]) win = i;
      c = '0;
      full = 1'b1;
      if (fl) begin
         c = '0;
      end else if (st) begin
         c = mHeld; full = mHeldFull;
      end else if (!v) begin
         c = '0;
      end else if (acc) begin
         full = 1'b0;
         c.pcsrc = 3'd4; c.regwrite = 1'b1; c.regdst = 2'd3; c.memtoreg = 2'd3;
         c.exc = 2'd1; c.irqId = 2'(win);
      end else begin
         refCtrl(op, fn, c, full);
      end
      newPending = acc ? (mPending & ~(4'b0001 << win)) : mPending;
      newPending = newPending | (req & ~mPrev);
      e.ctrl = c; e.full = full; e.pending = newPending;
      sb.push_back(e);
      mHeld = c; mHeldFull = full; mPrev = req; mPending = newPending;
   endtask

   task automatic resetDut();
      @(negedge clk);
      resetN = 1'b0;
      sb.delete();
      #1;
      checks++;
      if ({pcsrc, sign, regwrite, memread, memwrite, alusrc1, alusrc2, extop, luop,
           regdst, memtoreg, alufun, excCause, irqId, irqPending} !== '0)
         begin
            errors++;
            $display("[TB] FAIL asyncReset: got pcsrc=%b regwrite=%b memread=%b alufun=%b pending=%b, required all zero",
                     pcsrc, regwrite, memread, alufun, irqPending);
         end
      mPending = '0; mPrev = '0; mHeld = '0; mHeldFull = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic checkOutput(input Expect e);
      CtrlView act;
      CtrlView va;
      CtrlView ve;
      act = '{pcsrc, sign, regwrite, memread, memwrite, alusrc1, alusrc2, extop, luop,
              regdst, memtoreg, alufun, excCause, irqId};
      va = visible(act, e.full, e.ctrl.exc);
      ve = visible(e.ctrl, e.full, e.ctrl.exc);
      checks++;
      if (va !== ve) begin
         errors++;
         $display("[TB] FAIL ctrl @%0t: got pcsrc=%b rw=%b regdst=%b m2r=%b alufun=%b exc=%b id=%0d (%h), required pcsrc=%b rw=%b regdst=%b m2r=%b alufun=%b exc=%b id=%0d (%h)",
                  $time, act.pcsrc, act.regwrite, act.regdst, act.memtoreg, act.alufun, act.exc, act.irqId, va,
                  ve.pcsrc, ve.regwrite, ve.regdst, ve.memtoreg, ve.alufun, ve.exc, ve.irqId, ve);
      end
      checks++;
      if (irqPending !== e.pending) begin
         errors++;
         $display("[TB] FAIL irqPending @%0t: got %b, required %b", $time, irqPending, e.pending);
      end
   endtask

   initial begin : monitor
      Expect e;
      forever begin
         @(posedge clk);
         #1;
         if (resetN && sb.size() > 0) begin
            e = sb.pop_front();
            checkOutput(e);
         end
      end
   end

   initial begin : driver
      logic [5:0] opList[19];
      logic [5:0] fnList[17];
      logic [3:0] req;
      opList = '{6'h00, 6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07, 6'h08,
                 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0f, 6'h23, 6'h2b, 6'h3f, 6'h11};
      fnList = '{6'h00, 6'h02, 6'h03, 6'h08, 6'h09, 6'h0c, 6'h20, 6'h21, 6'h22,
                 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b, 6'h3f};
      resetDut();
      // Basic decode, then stall hold and release.
      applyStimulus(1, 6'h08, 6'h00, 0, 0, 0, 4'h0, 4'h0);
      applyStimulus(1, 6'h04, 6'h00, 0, 0, 0, 4'h0, 4'h0);
      repeat (3) applyStimulus(1, 6'h2b, 6'h00, 0, 1, 0, 4'h0, 4'h0);
      applyStimulus(1, 6'h2b, 6'h00, 0, 0, 0, 4'h0, 4'h0);
      applyStimulus(1, 6'h03, 6'h00, 0, 1, 1, 4'h0, 4'h0);
      // Arbitration between two simultaneous lines.
      applyStimulus(1, 6'h08, 6'h00, 0, 0, 0, 4'b0110, 4'hf);
      applyStimulus(1, 6'h08, 6'h00, 0, 0, 0, 4'b0000, 4'hf);
      applyStimulus(1, 6'h3f, 6'h00, 0, 0, 0, 4'b0000, 4'hf);
      applyStimulus(1, 6'h08, 6'h00, 0, 0, 0, 4'b0000, 4'hf);
      // Kernel gating, then a masked line that must stay pending.
      applyStimulus(1, 6'h08, 6'h00, 0, 0, 0, 4'b0001, 4'hf);
      repeat (3) applyStimulus(1, 6'h08, 6'h00, 1, 0, 0, 4'b0000, 4'hf);
      applyStimulus(1, 6'h08, 6'h00, 0, 0, 0, 4'b0000, 4'hf);
      applyStimulus(1, 6'h08, 6'h00, 0, 0, 0, 4'b0001, 4'h0);
      repeat (4) applyStimulus(1, 6'h08, 6'h00, 0, 0, 0, 4'b0000, 4'h0);
      applyStimulus(1, 6'h08, 6'h00, 0, 0, 0, 4'b0000, 4'hf);
      // Undefined opcode in kernel mode, syscall funct, idle slot.
      applyStimulus(1, 6'h3f, 6'h00, 1, 0, 0, 4'h0, 4'h0);
      applyStimulus(1, 6'h00, 6'h0c, 0, 0, 0, 4'h0, 4'h0);
      applyStimulus(0, 6'h23, 6'h00, 0, 0, 0, 4'h0, 4'h0);
      // Reset mid-run with lw in ID, then decode addi again.
      applyStimulus(1, 6'h23, 6'h00, 0, 0, 0, 4'h0, 4'h0);
      resetDut();
      applyStimulus(1, 6'h08, 6'h00, 0, 0, 0, 4'h0, 4'h0);
      req = '0;
      for (int n = 0; n < 600; n++) begin
         for (int b = 0; b < 4; b++) if ($urandom_range(5) == 0) req[b] = ~req[b];
         applyStimulus($urandom_range(7) != 0, opList[$urandom_range(18)], fnList[$urandom_range(16)],
                       $urandom_range(3) == 0, $urandom_range(6) == 0, $urandom_range(9) == 0,
                       req, 4'($urandom_range(15)));
         if (n == 300) resetDut();
      end
      repeat (3) @(negedge clk);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("[TB] FAIL drain: got %0d outstanding expectations, required 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ctrl_decode_pipe.md
Name: ctrl_decode_pipe

Overview:
- Second-generation main decoder for the 5-stage MIPS core.
- Decodes OpCode/Funct into the control bundle and registers it as the ID/EX control register, with stall/flush and bubble insertion.
- Includes an NUM_IRQ-channel interrupt arbiter with pending latches, mask and kernel-mode gating.
- Sits between the IF/ID register and the EX stage; drives the PC-select mux via the registered pcsrc.

Parameters:
- NUM_IRQ, 4, number of external interrupt lines (1..16).
- IRQ_ID_W, 2, width of irq_id; must be at least ceil(log2(NUM_IRQ)), minimum 1.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- id_valid  in  1  IF/ID holds a real instruction.
- opcode  in  6  instr[31:26].
- funct  in  6  instr[5:0].
- kernel  in  1  PC[31] of the ID instruction; 1 means kernel mode, IRQs blocked.
- stall  in  1  hold the ID/EX register.
- flush  in  1  load a bubble into the ID/EX register.
- irq_req  in  NUM_IRQ  level interrupt requests, synchronous to clk.
- irq_mask  in  NUM_IRQ  1 = line enabled.
- pcsrc  out  3  000 seq, 001 branch, 010 j/jal, 011 jr/jalr, 100 irq, 101 exception.
- sign, regwrite, memread, memwrite, alusrc1, alusrc2, extop, luop  out  1 each  registered control bits.
- regdst  out  2  00 rt, 01 rd, 10 $ra, 11 $k0 (xp).
- memtoreg  out  2  00 alu, 01 mem, 10 pc+4, 11 pc (irq).
- alufun  out  6  ALU function code.
- exc_cause  out  2  00 none, 01 irq, 10 undefined opcode, 11 syscall.
- irq_id  out  IRQ_ID_W  index of the accepted line; valid when exc_cause == 01.
- irq_pending  out  NUM_IRQ  current pending latches.

Behaviour:
- Reset (async, reset = 0): every output register holds the bubble: all 1-bit outputs 0, pcsrc/regdst/memtoreg/alufun/exc_cause/irq_id = 0. irq_pending = 0. Edge-detect history = 0.
- Decoded instruction set: R-type (00), bltz (01), j (02), jal (03), beq (04), bne (05), blez (06), bgtz (07), addi (08), addiu (09), slti (0a), sltiu (0b), andi (0c), lui (0f), lw (23), sw (2b). Any other opcode is undefined.
- Control values per instruction are the team's established encodings:
  - sign = 0 only for sltu and sltiu.
  - extop = 0 only for andi.
  - alusrc1 = 1 only for sll/srl/sra.
  - alusrc2 = 0 for R-type and beq.
  - alufun: add 000000, sub 000001, and 011000, or 011110, xor 010110, nor 010001, sll 100000, srl 100001, sra 100011, slt 110101, beq 110011, bne 110001, blez 111101, bgtz 111111, bltz 111011.
- Pending latches:
  - A bit sets on a rising edge of irq_req[i] (edge against the registered previous value).
  - A bit clears on the cycle its IRQ is accepted.
  - If set and clear hit the same bit in the same cycle, set wins.
- IRQ accept condition: id_valid & !stall & !flush & !kernel & |(irq_pending & irq_mask).
  - The lowest index wins.
  - Accepted bundle: pcsrc = 100, regwrite = 1, regdst = 11, memtoreg = 11, memread = memwrite = 0, exc_cause = 01, irq_id = winner.
  - The IRQ overrides the instruction's own decode, including an undefined opcode.
- Undefined opcode (no IRQ accepted, id_valid = 1): pcsrc = 101, regwrite = 1, regdst = 11, memtoreg = 10, exc_cause = 10. Undefined opcodes are not gated by kernel.
- Register update priority: flush > stall > load.
  - flush: load the bubble.
  - stall: hold all outputs; pending latches still set but never clear.
  - id_valid = 0 with no stall/flush: load the bubble.
- Latency: decode appears on the outputs 1 cycle after the ID inputs are sampled.
- Bubble guarantee: a bubble never asserts regwrite, memwrite or memread, and never asserts a nonzero pcsrc.

Optional Feature:
- Macro: CTRL_SYSCALL_EN.
- When defined: opcode 00 with funct 0c decodes as syscall: pcsrc = 101, regwrite = 1, regdst = 11, memtoreg = 10, exc_cause = 11. IRQ acceptance still has priority over syscall.
- When undefined: funct 0c is an ordinary unrecognised R-type funct, giving alufun = 000000, regwrite = 1, regdst = 01 and exc_cause = 00.

Test Plan:
- Reset: assert reset low mid-run with lw in ID -> all outputs 0 immediately (asynchronously). Release reset, decode addi -> next edge gives regwrite = 1, alusrc2 = 1, regdst = 00, alufun = 000000.
- Stall: decode beq, then hold stall = 1 for 3 cycles while opcode changes to sw -> outputs keep pcsrc = 001, alufun = 110011. Drop stall -> memwrite = 1 next edge.
- Flush over stall: stall = 1 and flush = 1 together with jal in ID -> bubble loaded, regwrite = 0, pcsrc = 000.
- IRQ arbitration: pulse irq_req = 0110, irq_mask = 1111, kernel = 0 -> next accepting cycle gives pcsrc = 100, irq_id = 1, irq_pending = 0100. The following accept gives irq_id = 2 and irq_pending = 0000.
- Gating: pending = 0001 with kernel = 1 -> no accept, pending stays set; when kernel goes to 0 -> accepted, exc_cause = 01. Masked line (irq_mask = 0) with pending = 0001 -> never accepted.
- Undefined/syscall: opcode 3f -> exc_cause = 10, pcsrc = 101, memtoreg = 10. Opcode 00/funct 0c -> exc_cause = 11 with CTRL_SYSCALL_EN defined, exc_cause = 00 without it.
